// File: rtl/spdif_tx_if.sv
// PCM sample-pair handshake between the mixer output and the S/PDIF transmitter.
interface spdif_tx_if;
    localparam int unsigned SAMPLE_W = 24;

    logic [SAMPLE_W-1:0] data_l_i;
    logic [SAMPLE_W-1:0] data_r_i;
    logic                valid_i;
    logic                ack_o;

    modport master (output data_l_i, output data_r_i, output valid_i, input ack_o);
    modport slave  (input data_l_i, input data_r_i, input valid_i, output ack_o);
endinterface

// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958 consumer) transmitter: latches one stereo PCM pair per frame and
// drives a biphase-mark-coded line with B/M/W preambles and V/U/C/P status bits.
module spdif_tx #(
    parameter int unsigned HALFBIT_DIV = 4,
    parameter logic [31:0] CS_WORD0    = 32'h0000_0004
) (
    input  logic      clk,
    input  logic      rst,
    spdif_tx_if.slave pcm,
    output logic      underrun_o,
    output logic      block_start_o,
    output logic      spdif_o
);
    localparam int unsigned       SAMPLE_W = 24;
    localparam int unsigned       DIV_W    = (HALFBIT_DIV > 1) ? $clog2(HALFBIT_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(HALFBIT_DIV - 1);
    localparam logic [6:0]        HB_LAST  = 7'd127;
    localparam logic [7:0]        FR_LAST  = 8'd191;
    localparam logic [7:0]        PRE_B    = 8'b1110_1000;
    localparam logic [7:0]        PRE_M    = 8'b1110_0010;
    localparam logic [7:0]        PRE_W    = 8'b1110_0100;

    logic [DIV_W-1:0]    div_cnt, div_nxt;
    logic [6:0]          hb, hb_nxt;
    logic [7:0]          fr, fr_nxt;
    logic                tick, tick_d, latch;
    logic [SAMPLE_W-1:0] smp_l, smp_r, smp_l_nxt, smp_r_nxt, smp;
    logic                vflag, vflag_nxt;
    logic                lvl, lvl_nxt, ref_lvl;
    logic                line, line_nxt;
    logic                ack_nxt, underrun_nxt, block_start_nxt;
    logic [5:0]          pos;
    logic [4:0]          slot, didx;
    logic                cs_bit, par;
    logic [27:0]         word;
    logic [7:0]          pat;

    // Timing, sample latch and BMC encoding of the position currently held in hb.
    always_comb begin
        tick            = (div_cnt == DIV_LAST);
        latch           = tick && (hb == HB_LAST);
        div_nxt         = tick ? '0 : div_cnt + DIV_W'(1);
        hb_nxt          = tick ? hb + 7'd1 : hb;
        fr_nxt          = fr;
        smp_l_nxt       = smp_l;
        smp_r_nxt       = smp_r;
        vflag_nxt       = vflag;
        ack_nxt         = 1'b0;
        underrun_nxt    = 1'b0;
        line_nxt        = spdif_o;
        lvl_nxt         = lvl;
        block_start_nxt = 1'b0;

        if (latch) begin
            fr_nxt       = (fr == FR_LAST) ? 8'd0 : fr + 8'd1;
            ack_nxt      = pcm.valid_i;
            underrun_nxt = !pcm.valid_i;
            vflag_nxt    = !pcm.valid_i;
            if (pcm.valid_i) begin
                smp_l_nxt = pcm.data_l_i;
                smp_r_nxt = pcm.data_r_i;
            end
        end

        pos     = hb[5:0];
        slot    = pos[5:1];
        didx    = slot - 5'd4;
        smp     = hb[6] ? smp_r : smp_l;
        cs_bit  = (fr < 8'd32) ? CS_WORD0[fr[4:0]] : 1'b0;
        par     = ^{smp, vflag, cs_bit};
        // Aux nibble carries sample[3:0], so the word is sample[23:0] LSB first from slot 4.
        word    = {par, cs_bit, 1'b0, vflag, smp};
        pat     = hb[6] ? PRE_W : ((fr == 8'd0) ? PRE_B : PRE_M);
        // Preamble is referenced to the line level just before its first half-bit.
        ref_lvl = (pos == 6'd0) ? spdif_o : lvl;

        if (pos < 6'd8) begin
            line = pat[3'd7 - pos[2:0]] ^ ref_lvl;
        end else if (!pos[0]) begin
            line = ~spdif_o;
        end else begin
            line = spdif_o ^ word[didx];
        end

        if (tick_d) begin
            line_nxt        = line;
            lvl_nxt         = ref_lvl;
            block_start_nxt = (hb == 7'd0) && (fr == 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            hb            <= HB_LAST;
            fr            <= FR_LAST;
            tick_d        <= 1'b0;
            smp_l         <= '0;
            smp_r         <= '0;
            vflag         <= 1'b0;
            lvl           <= 1'b0;
            spdif_o       <= 1'b0;
            pcm.ack_o     <= 1'b0;
            underrun_o    <= 1'b0;
            block_start_o <= 1'b0;
        end else begin
            div_cnt       <= div_nxt;
            hb            <= hb_nxt;
            fr            <= fr_nxt;
            tick_d        <= tick;
            smp_l         <= smp_l_nxt;
            smp_r         <= smp_r_nxt;
            vflag         <= vflag_nxt;
            lvl           <= lvl_nxt;
            spdif_o       <= line_nxt;
            pcm.ack_o     <= ack_nxt;
            underrun_o    <= underrun_nxt;
            block_start_o <= block_start_nxt;
        end
    end
endmodule
